// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the pipelined ALU: function codes for the 2-operand
//   and 1-operand classes, control codes, the decoded-operation enum and the
//   decode helper that applies the operation-class priority.
//   No ports (package).

package alu_pkg;

  // 2-operand function codes
  localparam logic [2:0] FUNC_ADD  = 3'b000;
  localparam logic [2:0] FUNC_ADDC = 3'b001;
  localparam logic [2:0] FUNC_SUB  = 3'b010;
  localparam logic [2:0] FUNC_SUBB = 3'b011;
  localparam logic [2:0] FUNC_AND  = 3'b100;
  localparam logic [2:0] FUNC_OR   = 3'b101;
  localparam logic [2:0] FUNC_XOR  = 3'b110;
  localparam logic [2:0] FUNC_XNOR = 3'b111;

  // 1-operand function codes
  localparam logic [2:0] FUNC_NOT    = 3'b000;
  localparam logic [2:0] FUNC_SHIFTL = 3'b001;
  localparam logic [2:0] FUNC_SHIFTR = 3'b010;
  localparam logic [2:0] FUNC_CP     = 3'b011;

  // Control instruction codes used by the surrounding processor decoder
  localparam logic [1:0] CTRL_STC   = 2'd0;
  localparam logic [1:0] CTRL_STB   = 2'd1;
  localparam logic [1:0] CTRL_RESET = 2'd2;
  localparam logic [1:0] CTRL_HALT  = 2'd3;

  typedef enum logic [4:0] {
    OP_ADD,
    OP_ADDC,
    OP_SUB,
    OP_SUBB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_XNOR,
    OP_NOT,
    OP_SHIFTL,
    OP_SHIFTR,
    OP_CP,
    OP_ADDI,
    OP_SUBI,
    OP_LS,
    OP_STC,
    OP_STB,
    OP_NOP
  } alu_op_e;

  // Collapse the one-hot-ish class selects and function code into one op.
  // Earlier classes win when several selects are high; undefined 1-operand
  // codes and "no class selected" both become a NOP.
  function automatic alu_op_e decode_op(
    input logic       arith_2op,
    input logic       arith_1op,
    input logic       addi,
    input logic       subi,
    input logic       load_or_store,
    input logic       stc_cmd,
    input logic       stb_cmd,
    input logic [2:0] func
  );
    alu_op_e op;
    op = OP_NOP;
    if (arith_2op) begin
      case (func)
        FUNC_ADD:  op = OP_ADD;
        FUNC_ADDC: op = OP_ADDC;
        FUNC_SUB:  op = OP_SUB;
        FUNC_SUBB: op = OP_SUBB;
        FUNC_AND:  op = OP_AND;
        FUNC_OR:   op = OP_OR;
        FUNC_XOR:  op = OP_XOR;
        default:   op = OP_XNOR;
      endcase
    end else if (arith_1op) begin
      case (func)
        FUNC_NOT:    op = OP_NOT;
        FUNC_SHIFTL: op = OP_SHIFTL;
        FUNC_SHIFTR: op = OP_SHIFTR;
        FUNC_CP:     op = OP_CP;
        default:     op = OP_NOP;
      endcase
    end else if (addi) begin
      op = OP_ADDI;
    end else if (subi) begin
      op = OP_SUBI;
    end else if (load_or_store) begin
      op = OP_LS;
    end else if (stc_cmd) begin
      op = OP_STC;
    end else if (stb_cmd) begin
      op = OP_STB;
    end
    return op;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core
//   Purely combinational datapath of the ALU.
//   Ports:
//     op          decoded operation
//     op_a, op_b  register operands
//     imm_ext     immediate, already sign-extended to WIDTH
//     carry_in    current carry flag
//     borrow_in   current borrow flag
//     result      WIDTH-bit result (modulo 2^WIDTH)
//     carry_next / carry_we    new carry value and its write enable
//     borrow_next / borrow_we  new borrow value and its write enable

module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic             carry_in,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_next,
  output logic             borrow_next,
  output logic             carry_we,
  output logic             borrow_we
);

  // Arithmetic runs one bit wider on zero-extended operands; the extra top
  // bit is the carry for additions and the borrow for subtractions.
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] i_ext;
  logic [WIDTH:0] c_ext;
  logic [WIDTH:0] w_ext;
  logic [WIDTH:0] wide;

  assign a_ext = {1'b0, op_a};
  assign b_ext = {1'b0, op_b};
  assign i_ext = {1'b0, imm_ext};
  assign c_ext = {{WIDTH{1'b0}}, carry_in};
  assign w_ext = {{WIDTH{1'b0}}, borrow_in};

  always_comb begin
    wide        = '0;
    result      = '0;
    carry_next  = 1'b0;
    borrow_next = 1'b0;
    carry_we    = 1'b0;
    borrow_we   = 1'b0;
    case (op)
      OP_ADD, OP_ADDC, OP_ADDI: begin
        if (op == OP_ADD)       wide = a_ext + b_ext;
        else if (op == OP_ADDC) wide = a_ext + b_ext + c_ext;
        else                    wide = a_ext + i_ext;
        result     = wide[WIDTH-1:0];
        carry_next = wide[WIDTH];
        carry_we   = 1'b1;
      end
      OP_SUB, OP_SUBB, OP_SUBI: begin
        if (op == OP_SUB)       wide = a_ext - b_ext;
        else if (op == OP_SUBB) wide = a_ext - b_ext - w_ext;
        else                    wide = a_ext - i_ext;
        result      = wide[WIDTH-1:0];
        borrow_next = wide[WIDTH];
        borrow_we   = 1'b1;
      end
      OP_LS: begin
        wide   = a_ext + i_ext;
        result = wide[WIDTH-1:0];
      end
      OP_AND:    result = op_a & op_b;
      OP_OR:     result = op_a | op_b;
      OP_XOR:    result = op_a ^ op_b;
      OP_XNOR:   result = ~(op_a ^ op_b);
      OP_NOT:    result = ~op_a;
      OP_SHIFTL: result = {op_a[WIDTH-2:0], 1'b0};
      OP_SHIFTR: result = {1'b0, op_a[WIDTH-1:1]};
      OP_CP:     result = op_a;
      OP_STC: begin
        carry_next = 1'b1;
        carry_we   = 1'b1;
      end
      OP_STB: begin
        borrow_next = 1'b1;
        borrow_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
//   Two-stage pipelined ALU. S1 registers the decoded instruction and its
//   operands, S2 holds the computed result. Carry and borrow live here as
//   flag registers so chained ADDC/SUBB see the previous instruction's flag.
//   Ports:
//     clk_pi, reset_n_pi           clock (rising edge), async active-low reset
//     in_valid_pi / in_ready_po    upstream handshake
//     *_pi class selects, alu_func_pi, reg1/reg2/immediate   instruction
//     flush_pi                     drop the instruction held in S1
//     out_valid_po / out_ready_pi  downstream handshake
//     alu_result_po, zero_po       registered result and its zero indication
//     carry_out_po, borrow_out_po  flag registers

module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 6
) (
  input  logic             clk_pi,
  input  logic             reset_n_pi,
  input  logic             in_valid_pi,
  output logic             in_ready_po,
  input  logic             arith_2op_pi,
  input  logic             arith_1op_pi,
  input  logic             addi_pi,
  input  logic             subi_pi,
  input  logic             load_or_store_pi,
  input  logic             stc_cmd_pi,
  input  logic             stb_cmd_pi,
  input  logic [2:0]       alu_func_pi,
  input  logic [WIDTH-1:0] reg1_data_pi,
  input  logic [WIDTH-1:0] reg2_data_pi,
  input  logic [IMM_W-1:0] immediate_pi,
  input  logic             flush_pi,
  output logic             out_valid_po,
  input  logic             out_ready_pi,
  output logic [WIDTH-1:0] alu_result_po,
  output logic             zero_po,
  output logic             carry_out_po,
  output logic             borrow_out_po
);

  logic             s1_valid;
  alu_op_e          s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [IMM_W-1:0] s1_imm;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             carry_q;
  logic             borrow_q;

  logic             s1_advance;
  logic             s1_commit;
  logic             in_xfer;
  logic [WIDTH-1:0] imm_ext;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_borrow;
  logic             core_carry_we;
  logic             core_borrow_we;

  // S1 may advance whenever S2 is empty or being drained. A flush still lets
  // S1 refill from upstream but kills the instruction that would have moved,
  // so it never reaches S2 and never touches the flags.
  assign s1_advance  = s1_valid && (!s2_valid || out_ready_pi);
  assign s1_commit   = s1_advance && !flush_pi;
  assign in_ready_po = !s1_valid || s1_advance;
  assign in_xfer     = in_valid_pi && in_ready_po;
  assign imm_ext     = {{(WIDTH-IMM_W){s1_imm[IMM_W-1]}}, s1_imm};

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op          (s1_op),
    .op_a        (s1_a),
    .op_b        (s1_b),
    .imm_ext     (imm_ext),
    .carry_in    (carry_q),
    .borrow_in   (borrow_q),
    .result      (core_result),
    .carry_next  (core_carry),
    .borrow_next (core_borrow),
    .carry_we    (core_carry_we),
    .borrow_we   (core_borrow_we)
  );

  // Decode stage: capture a new instruction on transfer, otherwise empty out
  // when the held instruction moves on or is flushed.
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_NOP;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_imm   <= '0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
      s1_op    <= decode_op(arith_2op_pi, arith_1op_pi, addi_pi, subi_pi,
                            load_or_store_pi, stc_cmd_pi, stb_cmd_pi,
                            alu_func_pi);
      s1_a     <= reg1_data_pi;
      s1_b     <= reg2_data_pi;
      s1_imm   <= immediate_pi;
    end else if (s1_advance || flush_pi) begin
      s1_valid <= 1'b0;
    end
  end

  // Execute/output stage and flag registers: results and flag updates are
  // committed together so the flags always belong to the newest result.
  always_ff @(posedge clk_pi or negedge reset_n_pi) begin
    if (!reset_n_pi) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      carry_q   <= 1'b0;
      borrow_q  <= 1'b0;
    end else begin
      if (s1_commit) begin
        s2_valid  <= 1'b1;
        s2_result <= core_result;
        if (core_carry_we)  carry_q  <= core_carry;
        if (core_borrow_we) borrow_q <= core_borrow;
      end else if (out_ready_pi) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid_po  = s2_valid;
  assign alu_result_po = s2_result;
  assign zero_po       = s2_valid && (s2_result == '0);
  assign carry_out_po  = carry_q;
  assign borrow_out_po = borrow_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
//   Self-checking bench for alu_pipe: a reference model computes each
//   instruction's result and flags when it is driven and queues them; a
//   monitor pops and compares whenever the DUT hands a result downstream.

module tb_alu_pipe;

  localparam int WIDTH = 16;
  localparam int IMM_W = 6;

  localparam logic [6:0] SEL_2OP = 7'b0000001;
  localparam logic [6:0] SEL_1OP = 7'b0000010;
  localparam logic [6:0] SEL_ADI = 7'b0000100;
  localparam logic [6:0] SEL_SBI = 7'b0001000;
  localparam logic [6:0] SEL_LS  = 7'b0010000;
  localparam logic [6:0] SEL_STC = 7'b0100000;
  localparam logic [6:0] SEL_STB = 7'b1000000;
  localparam logic [6:0] SEL_NOP = 7'b0000000;

  typedef struct {
    logic [6:0]       sel;
    logic [2:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [IMM_W-1:0] imm;
  } instr_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             b;
  } exp_t;

  logic             clk_pi;
  logic             reset_n_pi;
  logic             in_valid_pi;
  logic             in_ready_po;
  logic             arith_2op_pi;
  logic             arith_1op_pi;
  logic             addi_pi;
  logic             subi_pi;
  logic             load_or_store_pi;
  logic             stc_cmd_pi;
  logic             stb_cmd_pi;
  logic [2:0]       alu_func_pi;
  logic [WIDTH-1:0] reg1_data_pi;
  logic [WIDTH-1:0] reg2_data_pi;
  logic [IMM_W-1:0] immediate_pi;
  logic             flush_pi;
  logic             out_valid_po;
  logic             out_ready_pi;
  logic [WIDTH-1:0] alu_result_po;
  logic             zero_po;
  logic             carry_out_po;
  logic             borrow_out_po;

  int   testsRun;
  int   testsFailed;
  exp_t sb[$];
  exp_t monExp;
  bit   mCarry;
  bit   mBorrow;

  alu_pipe #(
    .WIDTH (WIDTH),
    .IMM_W (IMM_W)
  ) dut (
    .clk_pi           (clk_pi),
    .reset_n_pi       (reset_n_pi),
    .in_valid_pi      (in_valid_pi),
    .in_ready_po      (in_ready_po),
    .arith_2op_pi     (arith_2op_pi),
    .arith_1op_pi     (arith_1op_pi),
    .addi_pi          (addi_pi),
    .subi_pi          (subi_pi),
    .load_or_store_pi (load_or_store_pi),
    .stc_cmd_pi       (stc_cmd_pi),
    .stb_cmd_pi       (stb_cmd_pi),
    .alu_func_pi      (alu_func_pi),
    .reg1_data_pi     (reg1_data_pi),
    .reg2_data_pi     (reg2_data_pi),
    .immediate_pi     (immediate_pi),
    .flush_pi         (flush_pi),
    .out_valid_po     (out_valid_po),
    .out_ready_pi     (out_ready_pi),
    .alu_result_po    (alu_result_po),
    .zero_po          (zero_po),
    .carry_out_po     (carry_out_po),
    .borrow_out_po    (borrow_out_po)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk_pi = 1'b0;
  always #5 clk_pi = ~clk_pi;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(input logic [6:0] sel, input logic [2:0] func,
                                input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b,
                                input logic [IMM_W-1:0] imm);
    instr_t t;
    t.sel  = sel;
    t.func = func;
    t.a    = a;
    t.b    = b;
    t.imm  = imm;
    return t;
  endfunction

  // Reference model: integer arithmetic with explicit range tests for the
  // flags, class priority by if-chain, flags advanced in issue order.
  function automatic void modelPush(input instr_t t);
    int               av;
    int               bv;
    int               iv;
    int               full;
    logic [WIDTH-1:0] ix;
    exp_t             e;
    ix   = {{(WIDTH-IMM_W){t.imm[IMM_W-1]}}, t.imm};
    av   = int'(t.a);
    bv   = int'(t.b);
    iv   = int'(ix);
    full = 0;
    if (t.sel[0]) begin
      case (t.func)
        3'd0: begin full = av + bv;               mCarry  = (full > 65535); end
        3'd1: begin full = av + bv + int'(mCarry); mCarry  = (full > 65535); end
        3'd2: begin full = av - bv;               mBorrow = (full < 0);     end
        3'd3: begin full = av - bv - int'(mBorrow); mBorrow = (full < 0);   end
        3'd4: full = av & bv;
        3'd5: full = av | bv;
        3'd6: full = av ^ bv;
        default: full = ~(av ^ bv);
      endcase
    end else if (t.sel[1]) begin
      case (t.func)
        3'd0: full = ~av;
        3'd1: full = av * 2;
        3'd2: full = av / 2;
        3'd3: full = av;
        default: full = 0;
      endcase
    end else if (t.sel[2]) begin
      full = av + iv;
      mCarry = (full > 65535);
    end else if (t.sel[3]) begin
      full = av - iv;
      mBorrow = (full < 0);
    end else if (t.sel[4]) begin
      full = av + iv;
    end else if (t.sel[5]) begin
      mCarry = 1'b1;
    end else if (t.sel[6]) begin
      mBorrow = 1'b1;
    end
    e.res = full[WIDTH-1:0];
    e.c   = mCarry;
    e.b   = mBorrow;
    sb.push_back(e);
  endfunction

  task automatic setIdle();
    in_valid_pi      = 1'b0;
    arith_2op_pi     = 1'b0;
    arith_1op_pi     = 1'b0;
    addi_pi          = 1'b0;
    subi_pi          = 1'b0;
    load_or_store_pi = 1'b0;
    stc_cmd_pi       = 1'b0;
    stb_cmd_pi       = 1'b0;
    alu_func_pi      = 3'd0;
    reg1_data_pi     = '0;
    reg2_data_pi     = '0;
    immediate_pi     = '0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic waitAccept();
    bit accepted;
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk_pi);
      if (in_ready_po) begin
        @(posedge clk_pi);
        #1;
        accepted = 1'b1;
      end
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid_pi = 1'b0;
  endtask

  task automatic applyStimulus(input instr_t t, input bit keep,
                               input bit waitIt);
    arith_2op_pi     = t.sel[0];
    arith_1op_pi     = t.sel[1];
    addi_pi          = t.sel[2];
    subi_pi          = t.sel[3];
    load_or_store_pi = t.sel[4];
    stc_cmd_pi       = t.sel[5];
    stb_cmd_pi       = t.sel[6];
    alu_func_pi      = t.func;
    reg1_data_pi     = t.a;
    reg2_data_pi     = t.b;
    immediate_pi     = t.imm;
    in_valid_pi      = 1'b1;
    if (keep) modelPush(t);
    if (waitIt) waitAccept();
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 50 && (sb.size() != 0 || out_valid_po); i++) begin
      @(posedge clk_pi);
      #1;
    end
    checkOutput(tag, sb.size(), 32'd0);
  endtask

  task automatic nextCycle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_pi);
      #1;
    end
  endtask

  // Output monitor: a result transfers on the coming edge when valid and
  // ready are both high at the falling edge.
  always @(negedge clk_pi) begin
    if (reset_n_pi && out_valid_po && out_ready_pi) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out", 32'd1, 32'd0);
      end else begin
        monExp = sb.pop_front();
        checkOutput("result", 32'(alu_result_po), 32'(monExp.res));
        checkOutput("zero", 32'(zero_po), 32'(monExp.res == '0));
        checkOutput("carry", 32'(carry_out_po), 32'(monExp.c));
        checkOutput("borrow", 32'(borrow_out_po), 32'(monExp.b));
      end
    end
  end

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    mCarry      = 1'b0;
    mBorrow     = 1'b0;
    setIdle();
    flush_pi     = 1'b0;
    out_ready_pi = 1'b1;
    reset_n_pi   = 1'b0;

    // Reset state
    #12;
    checkOutput("rst_out_valid", 32'(out_valid_po), 32'd0);
    checkOutput("rst_result", 32'(alu_result_po), 32'd0);
    checkOutput("rst_zero", 32'(zero_po), 32'd0);
    checkOutput("rst_carry", 32'(carry_out_po), 32'd0);
    checkOutput("rst_borrow", 32'(borrow_out_po), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready_po), 32'd1);
    #14;
    reset_n_pi = 1'b1;

    // ADD 0xFFFF + 1 with latency check, then chained ADDC
    applyStimulus(mk(SEL_2OP, 3'd0, 16'hFFFF, 16'h0001, '0), 1'b1, 1'b1);
    checkOutput("lat_s1", 32'(out_valid_po), 32'd0);
    applyStimulus(mk(SEL_2OP, 3'd1, 16'h0001, 16'h0001, '0), 1'b1, 1'b1);
    checkOutput("lat_s2", 32'(out_valid_po), 32'd1);
    waitDrain("drain_add");

    // SUB underflow, SUBI with a negative immediate, SUBB chaining
    applyStimulus(mk(SEL_2OP, 3'd2, 16'h0000, 16'h0001, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_SBI, 3'd0, 16'h0010, '0, 6'b111111), 1'b1, 1'b1);
    applyStimulus(mk(SEL_2OP, 3'd3, 16'h0005, 16'h0002, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_2OP, 3'd3, 16'h0005, 16'h0002, '0), 1'b1, 1'b1);

    // Logic, 1-operand, immediates, priority, invalid code, NOP, STB
    applyStimulus(mk(SEL_2OP, 3'd4, 16'hF0F0, 16'h3C3C, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_2OP, 3'd5, 16'hF0F0, 16'h3C3C, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_2OP, 3'd6, 16'hF0F0, 16'h3C3C, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_2OP, 3'd7, 16'hF0F0, 16'h3C3C, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_1OP, 3'd0, 16'h1234, '0, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_1OP, 3'd1, 16'h8001, '0, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_1OP, 3'd2, 16'h8001, '0, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_1OP, 3'd3, 16'hBEEF, '0, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_1OP, 3'd5, 16'hBEEF, '0, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_ADI, 3'd0, 16'hFFFE, '0, 6'b000011), 1'b1, 1'b1);
    applyStimulus(mk(SEL_LS, 3'd0, 16'h0100, '0, 6'b100000), 1'b1, 1'b1);
    applyStimulus(mk(SEL_2OP | SEL_ADI, 3'd0, 16'h0005, 16'h0007, 6'd1),
                  1'b1, 1'b1);
    applyStimulus(mk(SEL_SBI | SEL_STB, 3'd0, 16'h0009, '0, 6'd2), 1'b1, 1'b1);
    applyStimulus(mk(SEL_NOP, 3'd0, 16'h1111, 16'h2222, 6'd3), 1'b1, 1'b1);
    applyStimulus(mk(SEL_STB, 3'd0, '0, '0, '0), 1'b1, 1'b1);
    waitDrain("drain_mix");

    // Stall: two instructions fill the pipe, the third waits
    out_ready_pi = 1'b0;
    applyStimulus(mk(SEL_2OP, 3'd0, 16'h0101, 16'h0202, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_2OP, 3'd6, 16'h00FF, 16'h0F0F, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_1OP, 3'd0, 16'h00FF, '0, '0), 1'b1, 1'b0);
    checkOutput("stall_in_ready", 32'(in_ready_po), 32'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle(1);
      checkOutput("stall_ready_low", 32'(in_ready_po), 32'd0);
      checkOutput("stall_valid", 32'(out_valid_po), 32'd1);
      checkOutput("stall_hold", 32'(alu_result_po), 32'(sb[0].res));
    end
    out_ready_pi = 1'b1;
    waitAccept();
    waitDrain("drain_stall");

    // STC, then flush the following ADDC while it sits in S1
    applyStimulus(mk(SEL_STC, 3'd0, '0, '0, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_2OP, 3'd1, 16'hFFFF, 16'hFFFF, '0), 1'b0, 1'b1);
    flush_pi = 1'b1;
    nextCycle(1);
    flush_pi = 1'b0;
    nextCycle(3);
    checkOutput("flush_no_out", 32'(out_valid_po), 32'd0);
    checkOutput("flush_carry", 32'(carry_out_po), 32'd1);
    checkOutput("flush_sb_empty", sb.size(), 32'd0);
    applyStimulus(mk(SEL_2OP, 3'd1, 16'h0001, 16'h0002, '0), 1'b1, 1'b1);
    waitDrain("drain_flush");

    // Asynchronous reset in the middle of a stall with carry set
    out_ready_pi = 1'b0;
    applyStimulus(mk(SEL_STC, 3'd0, '0, '0, '0), 1'b1, 1'b1);
    applyStimulus(mk(SEL_2OP, 3'd0, 16'h0001, 16'h0001, '0), 1'b1, 1'b1);
    nextCycle(1);
    checkOutput("pre_rst_carry", 32'(carry_out_po), 32'd1);
    checkOutput("pre_rst_valid", 32'(out_valid_po), 32'd1);
    #2;
    reset_n_pi = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid_po), 32'd0);
    checkOutput("arst_result", 32'(alu_result_po), 32'd0);
    checkOutput("arst_carry", 32'(carry_out_po), 32'd0);
    checkOutput("arst_borrow", 32'(borrow_out_po), 32'd0);
    checkOutput("arst_zero", 32'(zero_po), 32'd0);
    sb.delete();
    mCarry  = 1'b0;
    mBorrow = 1'b0;
    out_ready_pi = 1'b1;
    @(posedge clk_pi);
    #1;
    reset_n_pi = 1'b1;
    nextCycle(1);
    checkOutput("post_rst_ready", 32'(in_ready_po), 32'd1);
    checkOutput("post_rst_carry", 32'(carry_out_po), 32'd0);
    checkOutput("post_rst_valid", 32'(out_valid_po), 32'd0);
    applyStimulus(mk(SEL_2OP, 3'd1, 16'h7FFF, 16'h0001, '0), 1'b1, 1'b1);
    waitDrain("drain_final");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the processor's combinational ALU.
- Registers operands in a decode stage (S1), then computes and holds the result in an execute/output stage (S2), with valid/ready handshakes on both sides.
- Carry and borrow become architectural flag registers owned by the block, so ADDC/SUBB and STC/STB chain correctly across back-to-back instructions.
- Sits between register-file read and writeback in the datapath. PC adder and branch comparators stay outside.

Parameters:
- WIDTH, 16, datapath width in bits. Must be greater than IMM_W.
- IMM_W, 6, immediate field width. Sign-extended to WIDTH.

Ports:
- clk_pi  in  1  clock, rising edge
- reset_n_pi  in  1  asynchronous active-low reset
- in_valid_pi  in  1  upstream instruction valid
- in_ready_po  out  1  block can accept an instruction this cycle
- arith_2op_pi, arith_1op_pi, addi_pi, subi_pi, load_or_store_pi, stc_cmd_pi, stb_cmd_pi  in  1 each  operation class select
- alu_func_pi  in  3  function code (2op: ADD 000, ADDC 001, SUB 010, SUBB 011, AND 100, OR 101, XOR 110, XNOR 111; 1op: NOT 000, SHIFTL 001, SHIFTR 010, CP 011)
- reg1_data_pi  in  WIDTH  operand 1
- reg2_data_pi  in  WIDTH  operand 2
- immediate_pi  in  IMM_W  immediate operand
- flush_pi  in  1  drop the instruction held in S1
- out_valid_po  out  1  S2 holds a result
- out_ready_pi  in  1  downstream accepts the result
- alu_result_po  out  WIDTH  registered result
- zero_po  out  1  alu_result_po == 0, qualified by out_valid_po
- carry_out_po  out  1  carry flag register
- borrow_out_po  out  1  borrow flag register

Behaviour:
- Reset: asynchronous, active-low. Clears S1/S2 valid bits, alu_result_po, carry_out_po and borrow_out_po to 0. A reset mid-operation discards all in-flight instructions.
- Handshakes:
  - Input transfer occurs when in_valid_pi && in_ready_po. S1 then captures all *_pi operands and the decoded operation.
  - S1 moves to S2 when S1 is valid and (!out_valid_po || out_ready_pi).
  - in_ready_po = !s1_valid || s1_moves, so S1 can refill in the same cycle it drains.
- Latency and throughput: 2 cycles from input transfer to out_valid_po. Throughput is 1 instruction per cycle without stalls.
- Stall: while out_valid_po && !out_ready_pi, S2 and S1 hold and in_ready_po is low if S1 is full. Output payload is stable while stalled.
- Decode priority when several select bits are high: arith_2op > arith_1op > addi > subi > load_or_store > stc > stb. With no select bit high, the instruction is a NOP: result 0, flags preserved, still produces out_valid.
- Compute: performed on the S1->S2 transfer, using the flag register values current in that cycle. A back-to-back ADD followed by ADDC therefore sees the ADD's carry.
  - Arithmetic is done at WIDTH+1 bits with zero-extended operands.
  - ADD/ADDC/ADDI: carry_q <= bit WIDTH. ADDC adds carry_q.
  - SUB/SUBB/SUBI: borrow_q <= bit WIDTH (the borrow). SUBB subtracts borrow_q.
  - ADDI/SUBI: reg1 ± sext(immediate).
  - load_or_store: reg1 + sext(immediate); no flag update.
  - Logic ops and 1op functions: no flag update. SHIFTL/SHIFTR shift by 1 with zero fill.
  - STC: result 0, carry_q <= 1. STB: result 0, borrow_q <= 1.
  - Invalid func codes (1op 100-111): result 0, flags preserved.
  - All other cases preserve both flags.
- Flush: flush_pi clears S1 valid in the same cycle.
  - Overrides any S1->S2 transfer: no flag commit and no result.
  - Does not block a simultaneous input transfer; the new instruction is captured.
  - Does not touch S2.
- Wrap-around: results are modulo 2^WIDTH. Only carry/borrow capture bit WIDTH.

Decomposition:
- Package alu_pkg holds:
  - class/func code constants (ADD..XNOR, NOT..CP, STC/STB/RESET/HALT control codes)
  - a decoded-op enum (OP_ADD, OP_ADDC, ..., OP_STC, OP_STB, OP_NOP)
- Sub-module alu_core: purely combinational.
  - Inputs: decoded op, operands, flags.
  - Outputs: result, next carry, next borrow, carry write-enable, borrow write-enable.
  - alu_pipe wraps it with the S1/S2 registers, handshake logic and flag registers.

Test Plan:
- Reset then ADD 0xFFFF+0x0001, out_ready_pi=1: 2 cycles later out_valid_po=1, result 0x0000, zero_po=1, carry_out_po=1.
- Back-to-back ADD 0xFFFF+1, then ADDC 0x0001+0x0001: second result 0x0003; carry_out_po goes 1 then 0.
- SUB 0x0000-0x0001 -> result 0xFFFF, borrow_out_po=1. Then SUBI reg1=0x0010, imm=6'b111111 (-1) -> 0x0011 with borrow 1.
- Hold out_ready_pi=0 for 3 cycles while issuing 3 instructions: in_ready_po drops after 2 are accepted; result is held stable; on release, results emerge in order, one per cycle.
- STC followed by flush_pi asserted while an ADDC sits in S1: ADDC produces no output, carry_out_po stays 1, and the next accepted instruction proceeds normally.
- Assert reset_n_pi=0 asynchronously mid-stall with carry=1: all outputs go to 0 immediately; after release, in_ready_po=1 and carry_out_po=0.
